// File: rtl/time_of_day_counter.sv
// time_of_day_counter: BCD HH:MM:SS time of day driven by a 1 Hz tick, with push-button set mode.
// Define CLOCK_12H_EN for 12 h operation with a PM flag; the default build counts 24 h.
module time_of_day_counter #(
    parameter logic [7:0] RESET_HH = 8'h00,
    parameter logic [7:0] RESET_MM = 8'h00,
    parameter logic [7:0] RESET_SS = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_clear,
    input  logic       i_tick,
    input  logic       i_mode,
    input  logic       i_inc_min,
    input  logic       i_inc_hr,
    output logic [3:0] o_sec_ones,
    output logic [2:0] o_sec_tens,
    output logic [3:0] o_min_ones,
    output logic [2:0] o_min_tens,
    output logic [3:0] o_hr_ones,
    output logic [1:0] o_hr_tens,
    output logic       o_min_carry,
    output logic       o_day_pulse,
    output logic       o_pm
);
    typedef enum logic {ST_RUN, ST_SET} state_t;
`ifdef CLOCK_12H_EN
    localparam bit         H12     = 1'b1;
    localparam logic [5:0] HH_LAST = 6'h11;
    localparam logic [5:0] HH_RST  = 6'h12;
`else
    localparam bit         H12     = 1'b0;
    localparam logic [5:0] HH_LAST = 6'h23;
    localparam logic [5:0] HH_RST  = RESET_HH[5:0];
`endif
    state_t     r_state;
    logic [2:0] r_s1, r_s2, r_hist;
    logic [6:0] r_ss, r_mm;
    logic [5:0] r_hh;
    logic       r_min_carry, r_day_pulse, r_pm;
    logic [2:0] w_rise;

    function automatic logic [6:0] inc_60(input logic [6:0] v);
        return v[3:0] == 4'd9 ? (v[6:4] == 3'd5 ? 7'h00 : {v[6:4] + 3'd1, 4'd0})
                              : {v[6:4], v[3:0] + 4'd1};
    endfunction

    // 12 h wraps 12 -> 01 (11 -> 12 falls out of the plain ones increment)
    function automatic logic [5:0] inc_hr(input logic [5:0] v);
        return v == (H12 ? 6'h12 : 6'h23) ? (H12 ? 6'h01 : 6'h00)
             : v[3:0] == 4'd9 ? {v[5:4] + 2'd1, 4'd0} : {v[5:4], v[3:0] + 4'd1};
    endfunction

    // bit 0 = mode, 1 = inc_min, 2 = inc_hr; entering SET needs a mode rising edge
    assign w_rise = r_s2 & ~r_hist;

    always_ff @(negedge i_clk or negedge i_clear) begin
        if (!i_clear) begin
            r_s1        <= '1;
            r_s2        <= '1;
            r_hist      <= '1;
            r_state     <= ST_RUN;
            r_hh        <= HH_RST;
            r_mm        <= RESET_MM[6:0];
            r_ss        <= RESET_SS[6:0];
            r_min_carry <= 1'b0;
            r_day_pulse <= 1'b0;
            r_pm        <= 1'b0;
        end else begin
            r_s1        <= {i_inc_hr, i_inc_min, i_mode};
            r_s2        <= r_s1;
            r_hist      <= r_s2;
            r_min_carry <= 1'b0;
            r_day_pulse <= 1'b0;
            if (r_state == ST_RUN) begin
                if (w_rise[0]) begin
                    r_state <= ST_SET;
                    r_ss    <= '0;
                end else if (i_tick) begin
                    r_ss <= inc_60(r_ss);
                    if (r_ss == 7'h59) begin
                        r_min_carry <= 1'b1;
                        r_mm        <= inc_60(r_mm);
                        if (r_mm == 7'h59) begin
                            r_hh <= inc_hr(r_hh);
                            if (r_hh == HH_LAST) begin
                                r_pm        <= H12 ? ~r_pm : 1'b0;
                                r_day_pulse <= H12 ? r_pm : 1'b1;
                            end
                        end
                    end
                end
            end else begin
                if (!r_s2[0]) r_state <= ST_RUN;
                if (w_rise[1]) r_mm <= inc_60(r_mm);
                if (w_rise[2]) begin
                    r_hh <= inc_hr(r_hh);
                    if (r_hh == HH_LAST) r_pm <= H12 ? ~r_pm : 1'b0;
                end
            end
        end
    end

    assign o_sec_ones  = r_ss[3:0];
    assign o_sec_tens  = r_ss[6:4];
    assign o_min_ones  = r_mm[3:0];
    assign o_min_tens  = r_mm[6:4];
    assign o_hr_ones   = r_hh[3:0];
    assign o_hr_tens   = r_hh[5:4];
    assign o_min_carry = r_min_carry;
    assign o_day_pulse = r_day_pulse;
    assign o_pm        = r_pm;
endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Downstream consumer of the clock-divider chain.
- Takes the single-cycle 1 Hz TICK pulse from the final divide stage and keeps BCD time of day (HH:MM:SS).
- Provides a set mode driven by two push-buttons.
- Digit outputs feed the seven-segment decode/display stage directly.

Parameters:
- RESET_HH, 8'h00, BCD hour loaded on reset (24 h build only); must be legal BCD 00-23.
- RESET_MM, 8'h00, BCD minute loaded on reset; must be legal BCD 00-59.
- RESET_SS, 8'h00, BCD second loaded on reset; must be legal BCD 00-59.

Ports:
- CLK  input  1  system clock; all state updates on the falling edge, same edge as the divider chain.
- CLEAR  input  1  asynchronous, active-low reset.
- TICK  input  1  1 Hz enable; high for exactly one CLK cycle.
- MODE  input  1  0 = RUN, 1 = SET; level, asynchronous to CLK.
- INC_MIN  input  1  minute-advance button; level, asynchronous.
- INC_HR  input  1  hour-advance button; level, asynchronous.
- SEC_ONES  output  4  BCD seconds units.
- SEC_TENS  output  3  BCD seconds tens.
- MIN_ONES  output  4  BCD minutes units.
- MIN_TENS  output  3  BCD minutes tens.
- HR_ONES  output  4  BCD hours units.
- HR_TENS  output  2  BCD hours tens.
- MIN_CARRY  output  1  one-cycle pulse on every :59 -> :00 seconds rollover in RUN.
- DAY_PULSE  output  1  one-cycle pulse on midnight rollover in RUN.
- PM  output  1  PM flag; constant 0 unless CLOCK_12H_EN.

Behaviour:
- Reset (CLEAR low):
  - Digits load RESET_HH/MM/SS.
  - State = RUN.
  - MIN_CARRY = DAY_PULSE = PM = 0.
  - Synchronizer and edge-history flops for MODE, INC_MIN and INC_HR load 1. A button held across reset release therefore produces no edge.
  - Reset takes effect immediately, mid-count or mid-set.
- Synchronizers: MODE, INC_MIN and INC_HR each pass through 2 flops. An edge detect on the synchronized value gives a one-cycle rising-edge strobe. Latency from input change to action is 3 falling edges.
- FSM, 2 states:
  - RUN -> SET when synchronized MODE = 1. On entry, seconds clear to 00.
  - SET -> RUN when synchronized MODE = 0. Seconds resume from 00; the first increment happens on the next TICK.
- RUN:
  - On a CLK edge with TICK = 1, seconds increment. The new value is visible after that same edge, so latency is 1 edge.
  - Rollover chain resolves within that single edge:
    - SS 59 -> 00 and minute +1; MIN_CARRY = 1 for that cycle.
    - MM 59 -> 00 and hour +1.
    - HH 23 -> 00; DAY_PULSE = 1 for that cycle.
  - Example: 23:59:59 + TICK -> 00:00:00 in one edge, with MIN_CARRY and DAY_PULSE both high for one cycle.
  - INC_MIN and INC_HR are ignored in RUN.
- SET:
  - TICK is ignored; seconds stay at 00.
  - MIN_CARRY and DAY_PULSE are held at 0.
  - Each INC_MIN strobe: minute +1, wrapping 59 -> 00 with no carry into hours.
  - Each INC_HR strobe: hour +1, wrapping 23 -> 00.
  - Simultaneous strobes: both apply in the same cycle.
- TICK arriving in the same cycle as a RUN -> SET transition is dropped.
- BCD rules: ones digits wrap 9 -> 0 with a carry into tens. Tens wrap at the field limit. Illegal BCD is never produced from legal reset values.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro CLOCK_12H_EN.
- Defined:
  - Hour range is 12, 01..11. Reset hour is 12 with PM = 0; RESET_HH is ignored.
  - 11 -> 12 toggles PM, both in RUN and on an INC_HR strobe in SET.
  - In RUN, the 12 -> 01 step does not toggle PM.
  - DAY_PULSE fires on 11:59:59 PM -> 12:00:00 AM.
- Undefined:
  - 24 h operation as described under Behaviour.
  - PM tied to 0.

Test Plan:
- Assert CLEAR low mid-count, then release with RESET_HH/MM/SS = 8'h12/8'h34/8'h56 -> outputs read 12:34:56, state RUN, pulses 0.
- From 00:00:58, apply 2 TICK pulses spaced 10 cycles apart -> 00:00:59, then 00:01:00 with MIN_CARRY high for exactly 1 cycle.
- From 23:59:59, apply 1 TICK -> 00:00:00 on the same edge, with MIN_CARRY and DAY_PULSE each high for 1 cycle.
- Drive MODE = 1 at 10:20:30, apply 3 INC_MIN presses, 15 INC_HR presses and TICKs -> 01:23:00 with seconds frozen. Then MODE = 0 and 1 TICK -> 01:23:01.
- Hold INC_MIN high through CLEAR release in SET -> no increment. In SET, press INC_MIN at 59 -> minutes 00 and hours unchanged. Press INC_MIN and INC_HR together -> both advance by 1.
- CLOCK_12H_EN build: from 11:59:59 AM, apply 1 TICK -> 12:00:00 with PM = 1. From 11:59:59 PM, apply 1 TICK -> 12:00:00 with PM = 0 and DAY_PULSE high for 1 cycle.
